// File: rtl/msrv32_pipe_pkg.sv
// Shared types for the msrv32 elastic pipeline register.
// The stage FSM states and occupancy encodings live here. Widths stay module parameters.
package msrv32_pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] occ_of(pipe_state_t s);
        logic [1:0] occ;
        case (s)
            PS_ONE:  occ = OCC_ONE;
            PS_FULL: occ = OCC_FULL;
            default: occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/msrv32_pipe_slot.sv
// One {valid, data, ctrl} holding register of the elastic stage.
// The parent supplies the next valid bit; the clear controls take priority over load.
module msrv32_pipe_slot #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_d_i,
    input  logic              load_i,
    input  logic              clr_ctrl_i,
    input  logic              clr_data_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d_i;
            if (clr_ctrl_i) begin
                ctrl_q <= '0;
            end else if (load_i) begin
                ctrl_q <= ctrl_i;
            end
            if (clr_data_i) begin
                data_q <= '0;
            end else if (load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/msrv32_pipe_reg_stage.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer and flush.
// The main slot drives the outputs; the skid slot absorbs one beat when downstream stalls.
module msrv32_pipe_reg_stage
    import msrv32_pipe_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned CTRL_W          = 16,
    parameter bit          FLUSH_ZERO_DATA = 1'b0
) (
    input  logic              ms_risc32_mp_clk_in,
    input  logic              ms_risc32_mp_rst_in,
    input  logic              flush_in,
    input  logic              in_valid_in,
    output logic              in_ready_out,
    input  logic [DATA_W-1:0] in_data_in,
    input  logic [CTRL_W-1:0] in_ctrl_in,
    output logic              out_valid_out,
    input  logic              out_ready_in,
    output logic [DATA_W-1:0] out_data_out,
    output logic [CTRL_W-1:0] out_ctrl_out,
    output logic [1:0]        occupancy_out
);

    pipe_state_t state_q, state_d;
    logic        ready_q;
    logic [1:0]  occ_q;

    logic              accept, emit;
    logic              mainLoad, skidLoad;
    logic              clrCtrl, clrData;
    logic              mainValid, skidValid;
    logic [DATA_W-1:0] mainDataIn, skidData;
    logic [CTRL_W-1:0] mainCtrlIn, skidCtrl;

    // Ready comes from a flop, so out_ready_in never reaches in_ready_out combinationally.
    assign in_ready_out = ready_q & ms_risc32_mp_rst_in;
    assign accept       = in_valid_in & in_ready_out;
    assign emit         = out_valid_out & out_ready_in;

    always_comb begin
        state_d  = state_q;
        mainLoad = 1'b0;
        skidLoad = 1'b0;
        case (state_q)
            PS_EMPTY: begin
                if (accept) begin
                    state_d  = PS_ONE;
                    mainLoad = 1'b1;
                end
            end
            PS_ONE: begin
                if (accept && !emit) begin
                    state_d  = PS_FULL;
                    skidLoad = 1'b1;
                end else if (accept && emit) begin
                    mainLoad = 1'b1;
                end else if (emit) begin
                    state_d = PS_EMPTY;
                end
            end
            PS_FULL: begin
                if (emit) begin
                    state_d  = PS_ONE;
                    mainLoad = 1'b1;
                end
            end
            default: state_d = PS_EMPTY;
        endcase
        // A flush discards everything, including a beat accepted in the same cycle.
        if (flush_in) begin
            state_d  = PS_EMPTY;
            mainLoad = 1'b0;
            skidLoad = 1'b0;
        end
    end

    always_ff @(posedge ms_risc32_mp_clk_in) begin
        if (!ms_risc32_mp_rst_in) begin
            state_q <= PS_EMPTY;
            ready_q <= 1'b1;
            occ_q   <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != PS_FULL);
            occ_q   <= occ_of(state_d);
        end
    end

    assign clrCtrl    = flush_in;
    assign clrData    = flush_in & FLUSH_ZERO_DATA;
    assign mainDataIn = skidValid ? skidData : in_data_in;
    assign mainCtrlIn = skidValid ? skidCtrl : in_ctrl_in;

    msrv32_pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk_i      (ms_risc32_mp_clk_in),
        .rst_ni     (ms_risc32_mp_rst_in),
        .valid_d_i  (state_d != PS_EMPTY),
        .load_i     (mainLoad),
        .clr_ctrl_i (clrCtrl),
        .clr_data_i (clrData),
        .data_i     (mainDataIn),
        .ctrl_i     (mainCtrlIn),
        .valid_o    (mainValid),
        .data_o     (out_data_out),
        .ctrl_o     (out_ctrl_out)
    );

    msrv32_pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk_i      (ms_risc32_mp_clk_in),
        .rst_ni     (ms_risc32_mp_rst_in),
        .valid_d_i  (state_d == PS_FULL),
        .load_i     (skidLoad),
        .clr_ctrl_i (clrCtrl),
        .clr_data_i (clrData),
        .data_i     (in_data_in),
        .ctrl_i     (in_ctrl_in),
        .valid_o    (skidValid),
        .data_o     (skidData),
        .ctrl_o     (skidCtrl)
    );

    assign out_valid_out = mainValid;
    assign occupancy_out = occ_q;

endmodule

// File: tb/tb_msrv32_pipe_reg_stage.sv
// Scoreboard bench: three stage instances (held data, zeroed data, 1-bit/64-bit widths) share one stimulus.
module tb_msrv32_pipe_reg_stage;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] ctrl;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [31:0] inData;
    logic [15:0] inCtrl;

    logic        aInReady, aOutValid;
    logic [31:0] aOutData;
    logic [15:0] aOutCtrl;
    logic [1:0]  aOcc;

    logic        bInReady, bOutValid;
    logic [31:0] bOutData;
    logic [15:0] bOutCtrl;
    logic [1:0]  bOcc;

    logic        cInReady, cOutValid;
    logic [0:0]  cInData, cOutData;
    logic [63:0] cInCtrl, cOutCtrl;
    logic [1:0]  cOcc;

    beat_t sb[$];
    int    assertCount = 0;
    int    failCount   = 0;

    assign cInData = inData[0];
    assign cInCtrl = {inData, inCtrl, ~inCtrl};

    always #5 clk = ~clk;

    msrv32_pipe_reg_stage #(.DATA_W(32), .CTRL_W(16), .FLUSH_ZERO_DATA(1'b0)) dutA (
        .ms_risc32_mp_clk_in (clk),
        .ms_risc32_mp_rst_in (rst),
        .flush_in            (flush),
        .in_valid_in         (inValid),
        .in_ready_out        (aInReady),
        .in_data_in          (inData),
        .in_ctrl_in          (inCtrl),
        .out_valid_out       (aOutValid),
        .out_ready_in        (outReady),
        .out_data_out        (aOutData),
        .out_ctrl_out        (aOutCtrl),
        .occupancy_out       (aOcc)
    );

    msrv32_pipe_reg_stage #(.DATA_W(32), .CTRL_W(16), .FLUSH_ZERO_DATA(1'b1)) dutB (
        .ms_risc32_mp_clk_in (clk),
        .ms_risc32_mp_rst_in (rst),
        .flush_in            (flush),
        .in_valid_in         (inValid),
        .in_ready_out        (bInReady),
        .in_data_in          (inData),
        .in_ctrl_in          (inCtrl),
        .out_valid_out       (bOutValid),
        .out_ready_in        (outReady),
        .out_data_out        (bOutData),
        .out_ctrl_out        (bOutCtrl),
        .occupancy_out       (bOcc)
    );

    msrv32_pipe_reg_stage #(.DATA_W(1), .CTRL_W(64), .FLUSH_ZERO_DATA(1'b0)) dutC (
        .ms_risc32_mp_clk_in (clk),
        .ms_risc32_mp_rst_in (rst),
        .flush_in            (flush),
        .in_valid_in         (inValid),
        .in_ready_out        (cInReady),
        .in_data_in          (cInData),
        .in_ctrl_in          (cInCtrl),
        .out_valid_out       (cOutValid),
        .out_ready_in        (outReady),
        .out_data_out        (cOutData),
        .out_ctrl_out        (cOutCtrl),
        .occupancy_out       (cOcc)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [15:0] c,
                                 input logic r, input logic f);
        inValid  = v;
        inData   = d;
        inCtrl   = c;
        outReady = r;
        flush    = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 time unit after each rising edge, so the falling edge sees this cycle's handshake.
    always @(negedge clk) begin
        if (rst && !flush && inValid && aInReady) begin
            sb.push_back('{data: inData, ctrl: inCtrl});
        end
    end

    always @(negedge clk) begin
        beat_t exp;
        if (!rst) begin
            checkOutput("rst_gate_ready", 64'(aInReady), 64'(0));
            checkOutput("rst_gate_valid", 64'(aOutValid), 64'(0));
        end else begin
            checkOutput("occ_le_2", 64'(aOcc <= 2'd2), 64'(1));
            checkOutput("ready_vs_occ", 64'(aInReady), 64'(aOcc != 2'd2));
            checkOutput("b_tracks_a", 64'({bInReady, bOutValid, bOcc}), 64'({aInReady, aOutValid, aOcc}));
            checkOutput("c_tracks_a", 64'({cInReady, cOutValid, cOcc}), 64'({aInReady, aOutValid, aOcc}));
            if (aOutValid && outReady) begin
                if (sb.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL sb_underflow: got beat 0x%0h, expected none at %0t", aOutData, $time);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("a_data", 64'(aOutData), 64'(exp.data));
                    checkOutput("a_ctrl", 64'(aOutCtrl), 64'(exp.ctrl));
                    checkOutput("b_data", 64'(bOutData), 64'(exp.data));
                    checkOutput("b_ctrl", 64'(bOutCtrl), 64'(exp.ctrl));
                    checkOutput("c_data", 64'(cOutData), 64'(exp.data[0]));
                    checkOutput("c_ctrl", cOutCtrl, {exp.data, exp.ctrl, ~exp.ctrl});
                end
            end
            if (flush) sb.delete();
        end
    end

    initial begin
        int          idx;
        logic        willAccept;
        logic [31:0] d;

        rst = 1'b0;
        applyStimulus(1'b1, 32'h99, 16'h99, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            checkOutput("rst_in_ready", 64'(aInReady), 64'(0));
            checkOutput("rst_out_valid", 64'(aOutValid), 64'(0));
            checkOutput("rst_occ", 64'(aOcc), 64'(0));
        end
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        tick();
        checkOutput("post_rst_ready", 64'(aInReady), 64'(1));
        checkOutput("post_rst_valid", 64'(aOutValid), 64'(0));

        // Full-rate stream: each beat visible the cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            d = 32'h10 + 32'(i);
            applyStimulus(1'b1, d, 16'h100 + 16'(i), 1'b1, 1'b0);
            tick();
            checkOutput("stream_valid", 64'(aOutValid), 64'(1));
            checkOutput("stream_data", 64'(aOutData), 64'(d));
            checkOutput("stream_occ", 64'(aOcc), 64'(1));
            checkOutput("stream_c_data", 64'(cOutData), 64'(d[0]));
        end
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_idle_valid", 64'(aOutValid), 64'(0));
        checkOutput("stream_idle_occ", 64'(aOcc), 64'(0));

        // Back-pressure: downstream stalls for cycles 2..5.
        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            applyStimulus(idx < 6, 32'hA0 + 32'(idx), 16'h0A00 + 16'(idx), !(cyc >= 2 && cyc < 6), 1'b0);
            willAccept = inValid && aInReady;
            tick();
            if (willAccept) idx++;
            if (cyc == 2) begin
                checkOutput("bp_full_occ", 64'(aOcc), 64'(2));
                checkOutput("bp_full_ready", 64'(aInReady), 64'(0));
            end
            if (cyc == 6) begin
                checkOutput("bp_recover_ready", 64'(aInReady), 64'(1));
                checkOutput("bp_recover_occ", 64'(aOcc), 64'(1));
            end
        end
        checkOutput("bp_all_sent", 64'(idx), 64'(6));
        checkOutput("bp_drained_occ", 64'(aOcc), 64'(0));
        checkOutput("bp_sb_empty", 64'(sb.size()), 64'(0));

        // Flush while FULL, with a beat offered in the flush cycle.
        applyStimulus(1'b1, 32'hDEADBEEF, 16'h00FF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h12345678, 16'h0F0F, 1'b0, 1'b0);
        tick();
        checkOutput("flush_pre_occ", 64'(aOcc), 64'(2));
        applyStimulus(1'b1, 32'h55555555, 16'h3333, 1'b0, 1'b1);
        tick();
        checkOutput("flush_valid", 64'(aOutValid), 64'(0));
        checkOutput("flush_occ", 64'(aOcc), 64'(0));
        checkOutput("flush_ready", 64'(aInReady), 64'(1));
        checkOutput("flush_a_ctrl", 64'(aOutCtrl), 64'(0));
        checkOutput("flush_a_data_held", 64'(aOutData), 64'(32'hDEADBEEF));
        checkOutput("flush_c_data_held", 64'(cOutData), 64'(1));
        checkOutput("flush_c_ctrl", cOutCtrl, 64'(0));
        checkOutput("flush_b_data_zero", 64'(bOutData), 64'(0));
        checkOutput("flush_b_ctrl", 64'(bOutCtrl), 64'(0));
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        repeat (2) tick();
        checkOutput("flush_no_ghost", 64'(aOutValid), 64'(0));
        checkOutput("flush_sb_empty", 64'(sb.size()), 64'(0));

        // Flush in ONE: the held beat drains in the flush cycle, the accepted one is discarded.
        applyStimulus(1'b1, 32'h77, 16'h0077, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h88, 16'h0088, 1'b1, 1'b1);
        tick();
        checkOutput("flush_one_valid", 64'(aOutValid), 64'(0));
        checkOutput("flush_one_occ", 64'(aOcc), 64'(0));
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        tick();
        checkOutput("flush_one_discard", 64'(aOutValid), 64'(0));

        // Random valid/ready traffic, checked by the scoreboard.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 16'($urandom),
                          1'($urandom_range(0, 1)), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 10 && aOcc != 2'd0; i++) tick();
        checkOutput("rand_drain_occ", 64'(aOcc), 64'(0));
        checkOutput("rand_sb_empty", 64'(sb.size()), 64'(0));

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
